rf_wb_queue: RTL and testbench
==============================

Name: rf_wb_queue

Overview:
- Write-side producer for the 32x32 register file write port (A3/WD/RFWr).
- Merges register writes from two sources into a small in-order FIFO:
  - the pipeline WB stage;
  - the multi-cycle mult/div unit (MD).
- Drains at most one write per cycle into the register file.
- Exposes a lookup port so decode can take pending (queued, not yet written) values ahead of stale register-file contents.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pipe_wr_valid  in  1  WB stage requests a write.
- pipe_wr_addr  in  5  WB destination register.
- pipe_wr_data  in  32  WB write data.
- wb_stall  out  1  pipe write cannot be accepted this cycle; WB must hold its request.
- md_wr_valid  in  1  MD unit requests a write.
- md_wr_addr  in  5  MD destination register.
- md_wr_data  in  32  MD write data.
- md_wr_ready  out  1  MD write accepted when md_wr_valid and md_wr_ready are both high.
- rf_hold  in  1  freeze draining (RF port busy / debug freeze).
- rf_A3  out  5  register-file write address.
- rf_WD  out  32  register-file write data.
- rf_RFWr  out  1  register-file write enable.
- q_A1  in  5  lookup address 1.
- q_hit1  out  1  a queued write to q_A1 exists.
- q_data1  out  32  data of the youngest queued write to q_A1.
- q_A2  in  5  lookup address 2.
- q_hit2  out  1  a queued write to q_A2 exists.
- q_data2  out  32  data of the youngest queued write to q_A2.
- count  out  AW+1  number of valid entries.

Behaviour:
- State: entry array {addr[4:0], data[31:0]} x DEPTH; head pointer (AW bits); tail pointer (AW bits); count (AW+1 bits).
  - Pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- Reset (async, any time, including mid-operation):
  - head = tail = count = 0.
  - All queued writes are discarded.
  - rf_RFWr = 0, q_hit1 = q_hit2 = 0, wb_stall = 0.
  - md_wr_ready = 1.
- Drain:
  - drain = (count != 0) && !rf_hold.
  - rf_RFWr = drain; rf_A3 and rf_WD = head entry (combinational).
  - rf_A3 = 0 and rf_WD = 0 when count == 0.
  - On posedge with drain: head advances by 1.
  - Latency: a write enqueued at edge N reaches the register file at the earliest at edge N+1, when the queue is empty and not held.
- Free slots (combinational): free = DEPTH - count + drain.
- Pipe enqueue:
  - wb_stall = (free == 0).
  - pipe_take = pipe_wr_valid && !wb_stall.
- MD enqueue:
  - md_wr_ready = (free - pipe_take) >= 1.
  - md_wr_ready does not depend on md_wr_valid.
  - md_take = md_wr_valid && md_wr_ready.
- Writes to r0:
  - A take with addr == 0 is accepted (handshake completes) but not enqueued.
  - It consumes no slot.
  - It is excluded from the free/ready computation of the other source.
- Same-cycle ordering:
  - When both sources take in the same cycle, the pipe entry is written at tail and the MD entry at tail+1.
  - The pipe entry is therefore older.
- Count update per posedge: count = count + (enqueued entries, 0..2) - drain.
  - Simultaneous enqueue and drain at count == DEPTH is legal; count stays DEPTH.
  - Overflow is impossible by construction.
  - Underflow is impossible because drain requires count != 0.
- Lookup (combinational, per port):
  - Search valid entries from head to head+count-1.
  - Hit on an address match when the address is nonzero.
  - Data = youngest (closest to tail) matching entry.
  - Lookup of address 0 never hits.
  - The entry being drained this cycle still participates in lookup.
  - Entries enqueued this cycle do not participate in lookup until the next cycle.
  - On a miss, q_data = 0.
- Readers use q_data when q_hit is set, otherwise the register-file read data.

Test Plan:
1. Reset, then pipe write r5 = 0x12345678 with queue empty:
   - Next cycle: rf_RFWr=1, rf_A3=5, rf_WD=0x12345678, count=1, q_hit1=1 for q_A1=5.
   - Following cycle: count=0, rf_RFWr=0.
2. Same cycle: pipe r3 = 0xA and MD r3 = 0xB:
   - Next cycle: q_data for r3 = 0xB (younger).
   - Drain order: r3=0xA, then r3=0xB.
3. rf_hold=1 while feeding pipe+MD pairs:
   - count climbs 0→2→4.
   - At count=4: wb_stall=1, md_wr_ready=0.
   - Release hold with pipe valid: stall clears, entry accepted, count stays 4 that cycle.
4. Pipe write r0 = 0xFFFF with MD valid at count=DEPTH-1, held:
   - pipe handshake completes, nothing enqueued.
   - md_wr_ready=1 and MD entry takes the last slot; count=4.
   - q_A1=0 never hits.
5. Assert rst mid-stream with count=3:
   - Outputs drop immediately without waiting for a clock: rf_RFWr=0, count=0, hits=0.
   - After deassertion, the first new write drains in order.
6. Wrap-around: 10 consecutive single pipe writes r1..r10 with hold pulses:
   - Writes are drained exactly in enqueue order.
   - Pointers wrap with no lost or duplicated entries.

Source files
------------

// File: rtl/rf_wb_queue.sv
// Register-file write queue: merges WB and mult/div writes in order,
// drains one per cycle, and forwards pending values to decode lookups.
//
// Ports:
//   clk, rst             clock; async active-high reset
//   pipe_wr_*, wb_stall  WB stage write request and back-pressure
//   md_wr_*, md_wr_ready MD unit write handshake
//   rf_hold              freeze draining
//   rf_A3/rf_WD/rf_RFWr  register-file write port
//   q_A*/q_hit*/q_data*  lookup of pending writes
//   count                number of queued entries
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_wr_valid,
  input  logic [4:0]    pipe_wr_addr,
  input  logic [31:0]   pipe_wr_data,
  output logic          wb_stall,
  input  logic          md_wr_valid,
  input  logic [4:0]    md_wr_addr,
  input  logic [31:0]   md_wr_data,
  output logic          md_wr_ready,
  input  logic          rf_hold,
  output logic [4:0]    rf_A3,
  output logic [31:0]   rf_WD,
  output logic          rf_RFWr,
  input  logic [4:0]    q_A1,
  output logic          q_hit1,
  output logic [31:0]   q_data1,
  input  logic [4:0]    q_A2,
  output logic          q_hit2,
  output logic [31:0]   q_data2,
  output logic [AW:0]   count
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  ent_t          mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] md_slot;
  logic [AW-1:0] idx;
  logic [AW:0]   free;
  logic          drain;
  logic          pipe_take;
  logic          pipe_enq;
  logic          md_take;
  logic          md_enq;

  assign drain = (count != '0) && !rf_hold;
  assign free  = DEPTH_C - count + (AW+1)'(drain);

  assign wb_stall  = (free == '0);
  assign pipe_take = pipe_wr_valid && !wb_stall;
  // r0 writes complete the handshake but never occupy a slot
  assign pipe_enq  = pipe_take && (pipe_wr_addr != 5'd0);

  assign md_wr_ready = free > (AW+1)'(pipe_enq);
  assign md_take     = md_wr_valid && md_wr_ready;
  assign md_enq      = md_take && (md_wr_addr != 5'd0);

  // pipe entry is older when both enqueue together
  assign md_slot = tail + AW'(pipe_enq);

  assign rf_RFWr = drain;
  assign rf_A3   = (count == '0) ? 5'd0  : mem[head].addr;
  assign rf_WD   = (count == '0) ? 32'd0 : mem[head].data;

  // scan oldest to youngest so the youngest match wins
  always_comb begin
    q_hit1  = 1'b0;
    q_data1 = 32'd0;
    q_hit2  = 1'b0;
    q_data2 = 32'd0;
    idx     = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((AW+1)'(i) < count) begin
        if (q_A1 != 5'd0 &&
            mem[idx].addr == q_A1) begin
          q_hit1  = 1'b1;
          q_data1 = mem[idx].data;
        end
        if (q_A2 != 5'd0 &&
            mem[idx].addr == q_A2) begin
          q_hit2  = 1'b1;
          q_data2 = mem[idx].data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (drain)
        head <= head + AW'(1);
      tail  <= tail + AW'(pipe_enq)
                    + AW'(md_enq);
      count <= count + (AW+1)'(pipe_enq)
                     + (AW+1)'(md_enq)
                     - (AW+1)'(drain);
    end
  end

  // storage needs no reset; count qualifies validity
  always_ff @(posedge clk) begin
    if (pipe_enq)
      mem[tail] <= '{pipe_wr_addr, pipe_wr_data};
    if (md_enq)
      mem[md_slot] <= '{md_wr_addr, md_wr_data};
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed scenarios plus random
// traffic, checked against a queue-based reference model.
module tb_rf_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          rst;
  logic          pipe_wr_valid;
  logic [4:0]    pipe_wr_addr;
  logic [31:0]   pipe_wr_data;
  logic          wb_stall;
  logic          md_wr_valid;
  logic [4:0]    md_wr_addr;
  logic [31:0]   md_wr_data;
  logic          md_wr_ready;
  logic          rf_hold;
  logic [4:0]    rf_A3;
  logic [31:0]   rf_WD;
  logic          rf_RFWr;
  logic [4:0]    q_A1;
  logic          q_hit1;
  logic [31:0]   q_data1;
  logic [4:0]    q_A2;
  logic          q_hit2;
  logic [31:0]   q_data2;
  logic [AW:0]   count;

  rf_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_valid(pipe_wr_valid),
    .pipe_wr_addr(pipe_wr_addr),
    .pipe_wr_data(pipe_wr_data),
    .wb_stall(wb_stall),
    .md_wr_valid(md_wr_valid),
    .md_wr_addr(md_wr_addr),
    .md_wr_data(md_wr_data),
    .md_wr_ready(md_wr_ready),
    .rf_hold(rf_hold),
    .rf_A3(rf_A3), .rf_WD(rf_WD),
    .rf_RFWr(rf_RFWr),
    .q_A1(q_A1), .q_hit1(q_hit1),
    .q_data1(q_data1),
    .q_A2(q_A2), .q_hit2(q_hit2),
    .q_data2(q_data2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void look(input logic [4:0] a,
                               output logic h,
                               output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a != 5'd0)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a == a) begin
          h = 1'b1;
          d = q[i].d;
          break;
        end
  endfunction

  // called just after a negedge with inputs set; returns at next negedge
  task automatic step();
    bit drn, pe, mr, me, st;
    int fr;
    logic h1, h2;
    logic [31:0] d1, d2;
    ent_t pent, ment;
    #1;
    drn = (q.size() != 0) && !rf_hold;
    fr  = DEPTH - q.size() + int'(drn);
    st  = (fr == 0);
    pe  = pipe_wr_valid && !st && (pipe_wr_addr != 0);
    mr  = (fr - int'(pe)) >= 1;
    me  = md_wr_valid && mr && (md_wr_addr != 0);
    pent = '{pipe_wr_addr, pipe_wr_data};
    ment = '{md_wr_addr, md_wr_data};
    look(q_A1, h1, d1);
    look(q_A2, h2, d2);
    chk("rfwr", 32'(rf_RFWr), 32'(drn));
    chk("a3", 32'(rf_A3), q.size() ? 32'(q[0].a) : 0);
    chk("wd", rf_WD, q.size() ? q[0].d : 0);
    chk("count", 32'(count), 32'(q.size()));
    chk("stall", 32'(wb_stall), 32'(st));
    chk("ready", 32'(md_wr_ready), 32'(mr));
    chk("hit1", 32'(q_hit1), 32'(h1));
    chk("data1", q_data1, d1);
    chk("hit2", 32'(q_hit2), 32'(h2));
    chk("data2", q_data2, d2);
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (pe) q.push_back(pent);
    if (me) q.push_back(ment);
    @(negedge clk);
  endtask

  task automatic idle();
    pipe_wr_valid = 1'b0;
    md_wr_valid   = 1'b0;
  endtask

  task automatic drain_all();
    idle();
    rf_hold = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++)
      step();
    chk("drained", 32'(count), 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    pipe_wr_addr = 0; pipe_wr_data = 0;
    md_wr_addr = 0; md_wr_data = 0;
    rf_hold = 1'b0;
    q_A1 = 0; q_A2 = 0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_rfwr", 32'(rf_RFWr), 0);
    chk("rst_stall", 32'(wb_stall), 0);
    chk("rst_ready", 32'(md_wr_ready), 1);
    chk("rst_hit1", 32'(q_hit1), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single pipe write, drains next cycle
    pipe_wr_valid = 1'b1;
    pipe_wr_addr = 5'd5;
    pipe_wr_data = 32'h12345678;
    step();
    idle();
    q_A1 = 5'd5;
    #1;
    chk("t1_rfwr", 32'(rf_RFWr), 1);
    chk("t1_a3", 32'(rf_A3), 5);
    chk("t1_wd", rf_WD, 32'h12345678);
    chk("t1_cnt", 32'(count), 1);
    chk("t1_hit", 32'(q_hit1), 1);
    step();
    chk("t1_cnt0", 32'(count), 0);
    chk("t1_rfwr0", 32'(rf_RFWr), 0);

    // 2: same-cycle pipe+MD to r3, MD younger
    pipe_wr_valid = 1'b1;
    pipe_wr_addr = 5'd3; pipe_wr_data = 32'hA;
    md_wr_valid = 1'b1;
    md_wr_addr = 5'd3; md_wr_data = 32'hB;
    step();
    idle();
    q_A1 = 5'd3;
    #1;
    chk("t2_young", q_data1, 32'hB);
    chk("t2_first", rf_WD, 32'hA);
    step();
    chk("t2_second", rf_WD, 32'hB);
    step();

    // 3: hold while filling, then release
    rf_hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pipe_wr_valid = 1'b1;
      pipe_wr_addr = 5'(6 + 2 * k);
      pipe_wr_data = 32'h100 + k;
      md_wr_valid = 1'b1;
      md_wr_addr = 5'(7 + 2 * k);
      md_wr_data = 32'h200 + k;
      step();
    end
    #1;
    chk("t3_cnt", 32'(count), 4);
    chk("t3_stall", 32'(wb_stall), 1);
    chk("t3_ready", 32'(md_wr_ready), 0);
    md_wr_valid = 1'b0;
    rf_hold = 1'b0;
    pipe_wr_addr = 5'd10;
    #1;
    chk("t3_unstall", 32'(wb_stall), 0);
    step();
    chk("t3_cnt4", 32'(count), 4);
    drain_all();

    // 4: r0 pipe write at DEPTH-1 lets MD take last slot
    rf_hold = 1'b1;
    pipe_wr_valid = 1'b1;
    pipe_wr_addr = 5'd12; pipe_wr_data = 32'h12;
    md_wr_valid = 1'b1;
    md_wr_addr = 5'd13; md_wr_data = 32'h13;
    step();
    md_wr_valid = 1'b0;
    pipe_wr_addr = 5'd14; pipe_wr_data = 32'h14;
    step();
    pipe_wr_addr = 5'd0; pipe_wr_data = 32'hFFFF;
    md_wr_valid = 1'b1;
    md_wr_addr = 5'd11; md_wr_data = 32'h11;
    q_A1 = 5'd0;
    #1;
    chk("t4_stall", 32'(wb_stall), 0);
    chk("t4_ready", 32'(md_wr_ready), 1);
    chk("t4_r0hit", 32'(q_hit1), 0);
    step();
    idle();
    #1;
    chk("t4_cnt", 32'(count), 4);
    chk("t4_r0hit2", 32'(q_hit1), 0);

    // 5: async reset mid-stream at count 3
    rf_hold = 1'b0;
    step();
    q_A1 = 5'd11;
    #3;
    rst = 1'b1;
    #1;
    chk("t5_cnt", 32'(count), 0);
    chk("t5_rfwr", 32'(rf_RFWr), 0);
    chk("t5_hit", 32'(q_hit1), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    pipe_wr_valid = 1'b1;
    pipe_wr_addr = 5'd20; pipe_wr_data = 32'h20;
    step();
    idle();
    #1;
    chk("t5_a3", 32'(rf_A3), 20);
    step();

    // 6: wrap-around with hold pulses
    for (int k = 1; k <= 10; k++) begin
      pipe_wr_valid = 1'b1;
      pipe_wr_addr = 5'(k);
      pipe_wr_data = 32'h111 * k;
      rf_hold = (k % 3 == 0);
      q_A2 = 5'(k - 1);
      step();
    end
    drain_all();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      pipe_wr_valid = 1'($urandom_range(0, 1));
      pipe_wr_addr = 5'($urandom_range(0, 7));
      pipe_wr_data = $urandom;
      md_wr_valid = 1'($urandom_range(0, 1));
      md_wr_addr = 5'($urandom_range(0, 7));
      md_wr_data = $urandom;
      rf_hold = ($urandom_range(0, 9) < 4);
      q_A1 = 5'($urandom_range(0, 7));
      q_A2 = 5'($urandom_range(0, 7));
      step();
    end
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
